// File: rtl/ttt_pkg.sv
// ttt_pkg: shared encodings for the tic-tac-toe game controller.
//   - status encodings driven on ttt_game_ctrl.status
//   - FSM state type for the controller
//   - full-board constant and player identifiers
package ttt_pkg;

    localparam logic [1:0] ST_PLAY = 2'b00;
    localparam logic [1:0] ST_AWIN = 2'b01;
    localparam logic [1:0] ST_BWIN = 2'b10;
    localparam logic [1:0] ST_DRAW = 2'b11;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [8:0] BOARD_FULL = 9'h1FF;

    localparam logic PLAYER_A = 1'b0;
    localparam logic PLAYER_B = 1'b1;

endpackage

// File: rtl/ttt_line_detect.sv
// ttt_line_detect: combinational three-in-a-row detector.
//   board : 9-bit occupancy of one player, bit i = square i (row-major 0..8)
//   lines : one-hot line hit
//           [2] row 0 (0,1,2)  [1] row 1 (3,4,5)  [0] row 2 (6,7,8)
//           [5] col 0 (0,3,6)  [4] col 1 (1,4,7)  [3] col 2 (2,5,8)
//           [6] diag (0,4,8)   [7] anti-diag (2,4,6)
module ttt_line_detect (
    input  logic [8:0] board,
    output logic [7:0] lines
);

    logic [7:0] hits;

    assign hits[2] = board[0] & board[1] & board[2];
    assign hits[1] = board[3] & board[4] & board[5];
    assign hits[0] = board[6] & board[7] & board[8];
    assign hits[5] = board[0] & board[3] & board[6];
    assign hits[4] = board[1] & board[4] & board[7];
    assign hits[3] = board[2] & board[5] & board[8];
    assign hits[6] = board[0] & board[4] & board[8];
    assign hits[7] = board[2] & board[4] & board[6];

    // A single move can close two lines at once; keep only the lowest
    // set bit so the output stays one-hot.
    assign lines = hits & (~hits + 8'd1);

endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: two-player tic-tac-toe sequencer.
//   clk, reset (sync, active-high), new_game (pulse: restart)
//   a_req/a_pos, b_req/b_pos : move requests, square index 0..8
//   ain, bin   : registered occupancy per player
//   turn       : player to move (0=A, 1=B)
//   status     : 00 playing, 01 A won, 10 B won, 11 draw
//   win_line   : one-hot winning line, 0 unless won
//   a_ack/b_ack, a_err/b_err, timeout : one-cycle result pulses
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter bit          START_PLAYER   = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TMR_W          = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       a_req,
    input  logic [3:0] a_pos,
    input  logic       b_req,
    input  logic [3:0] b_pos,
    output logic [8:0] ain,
    output logic [8:0] bin,
    output logic       turn,
    output logic [1:0] status,
    output logic [7:0] win_line,
    output logic       a_ack,
    output logic       b_ack,
    output logic       a_err,
    output logic       b_err,
    output logic       timeout
);

    localparam bit             TMR_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [TMR_W-1:0] TMR_LAST =
        (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state;
    logic [TMR_W-1:0] tmr;

    logic       cur_req;
    logic [3:0] cur_pos;
    logic [8:0] pos_mask;
    logic       cur_legal;
    logic [8:0] mover_board;
    logic [7:0] hit;

    assign cur_req   = (turn == PLAYER_B) ? b_req : a_req;
    assign cur_pos   = (turn == PLAYER_B) ? b_pos : a_pos;
    // Shift past bit 8 yields 0; the range check below rejects those anyway.
    assign pos_mask  = 9'b1 << cur_pos;
    assign cur_legal = cur_req && (cur_pos <= 4'd8) && (((ain | bin) & pos_mask) == 9'b0);

    // Only the player who just moved can have completed a line.
    assign mover_board = (turn == PLAYER_B) ? bin : ain;

    ttt_line_detect u_line_detect (
        .board (mover_board),
        .lines (hit)
    );

    always_ff @(posedge clk) begin
        a_ack   <= 1'b0;
        b_ack   <= 1'b0;
        a_err   <= 1'b0;
        b_err   <= 1'b0;
        timeout <= 1'b0;
        if (reset || new_game) begin
            ain      <= '0;
            bin      <= '0;
            status   <= ST_PLAY;
            win_line <= '0;
            tmr      <= '0;
            state    <= PLAY;
            turn     <= START_PLAYER;
        end else begin
            case (state)
                PLAY: begin
                    // Out-of-turn requests always err, even alongside a legal in-turn move.
                    a_err <= a_req && !((turn == PLAYER_A) && cur_legal);
                    b_err <= b_req && !((turn == PLAYER_B) && cur_legal);
                    if (cur_legal) begin
                        if (turn == PLAYER_B) begin
                            bin   <= bin | pos_mask;
                            b_ack <= 1'b1;
                        end else begin
                            ain   <= ain | pos_mask;
                            a_ack <= 1'b1;
                        end
                        tmr   <= '0;
                        state <= CHECK;
                    end else if (TMR_EN) begin
                        if (tmr == TMR_LAST) begin
                            timeout <= 1'b1;
                            turn    <= ~turn;
                            tmr     <= '0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    a_err <= a_req;
                    b_err <= b_req;
                    // Win is tested before full-board so a ninth-move win is not a draw.
                    if (|hit) begin
                        status   <= (turn == PLAYER_B) ? ST_BWIN : ST_AWIN;
                        win_line <= hit;
                        state    <= DONE;
                    end else if ((ain | bin) == BOARD_FULL) begin
                        status   <= ST_DRAW;
                        win_line <= '0;
                        state    <= DONE;
                    end else begin
                        turn  <= ~turn;
                        tmr   <= '0;
                        state <= PLAY;
                    end
                end
                DONE: begin
                    a_err <= a_req;
                    b_err <= b_req;
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule
